seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
Sequential restoring divider, the inverse operation of the team's 4x4 structural array multiplier. It takes an 8-bit dividend and a 4-bit divisor and produces an 8-bit quotient and 4-bit remainder, one quotient bit per clock. The block sits beside the multiplier in the arithmetic tile. Results are checked against the multiplier: quotient*divisor + remainder == dividend.

Parameters:
DIVIDEND_W, 8, dividend and quotient width; iteration count.
DIVISOR_W, 4, divisor and remainder width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
dividend  input  DIVIDEND_W  operand; captured when start is accepted.
divisor  input  DIVISOR_W  operand; captured when start is accepted.
busy  output  1  high while an operation is in RUN.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
quotient  output  DIVIDEND_W  result quotient.
remainder  output  DIVISOR_W  result remainder.
div_by_zero  output  1  set with done when captured divisor==0; held until next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Internal counter and partial remainder cleared.
  - Reset asserted mid-RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures the operands and clears the previous results and div_by_zero.
  - If divisor!=0: go to RUN, busy=1, iteration count=0, partial remainder P (DIVISOR_W+1 bits)=0.
  - If divisor==0: go directly to DONE. Set quotient=all ones (8'hFF), remainder=0, div_by_zero=1. done is high in the cycle after E0.
- RUN, one iteration per edge:
  - T = {P[DIVISOR_W-1:0], dividend_shift MSB}.
  - Shift dividend_shift left by one.
  - If T >= {1'b0, divisor}: P = T - divisor and shift 1 into the quotient LSB. Otherwise P = T and shift 0 in.
  - After DIVIDEND_W iterations (edge E_N, N=DIVIDEND_W): go to DONE, busy=0, remainder=P[DIVISOR_W-1:0].
- DONE:
  - done=1 for exactly one cycle, then return to IDLE on the next edge.
- Latency:
  - Normal operation: done is high in the cycle after edge E0+N (8 cycles after the start-sampling edge).
  - Divide by zero: done is high 1 cycle after E0.
- Results: quotient, remainder and div_by_zero are held stable after done until the next accepted start. Intermediate quotient bits may be visible on quotient during RUN; the bench checks only at done.
- start while busy or in DONE: ignored. The operands are not recaptured and the running result is unaffected.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE. Throughput is one result per N+2 cycles.
- Operands may change after the start-accept edge without affecting the result.
- Arithmetic:
  - Unsigned only.
  - Invariant: quotient*divisor + remainder == dividend, with remainder < divisor.
  - T never exceeds 2*divisor-1, so DIVISOR_W+1 bits suffice for T and P.
- busy and done are never high in the same cycle.

Test Plan:
- dividend=0xE1, divisor=0xF, start pulsed at E0 -> busy high 8 cycles; done one cycle later with quotient=0x0F, remainder=0x0, div_by_zero=0. Repeat with 0x5A/0x6 -> quotient=0x0F, remainder=0x0.
- Sweep 0x32/0x7 -> quotient=0x07, remainder=0x1; 0xFF/0x1 -> quotient=0xFF, remainder=0x0; 0x03/0x9 -> quotient=0x00, remainder=0x3; 0x00/0x5 -> quotient=0x00, remainder=0x0.
- dividend=0x40, divisor=0x0 -> done high the cycle after E0; quotient=0xFF, remainder=0x0, div_by_zero=1, busy never high. A following start with 0x40/0x8 -> div_by_zero cleared, quotient=0x08.
- During 0x69/0x7, pulse start with 0xFF/0x1 at iteration 3 -> ignored; result is quotient=0x0F, remainder=0x0. Then hold start high with 0x38/0x8 -> next result quotient=0x07, remainder=0x0, exactly N+2 cycles after the prior done.
- Deassert rst_n asynchronously mid-RUN (iteration 4 of 0xE1/0xF) -> busy, done, quotient and remainder go to 0 immediately, no done pulse follows, and the next start computes correctly.
- Exhaustive: all 256 dividends x 15 nonzero divisors -> quotient*divisor + remainder == dividend and remainder < divisor at every done, with zero failures reported.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider, one quotient bit per clock
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]  dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]   dsr_q, dsr_d;
    // The partial remainder is always below the divisor, so its top bit is
    // constant zero and only the low DIVISOR_W bits are stored.
    logic [DIVISOR_W-1:0]   p_q, p_d;
    logic [DIVIDEND_W-1:0]  quo_q, quo_d;
    logic [DIVISOR_W-1:0]   rem_q, rem_d;
    logic                   dbz_q, dbz_d;

    logic [DIVISOR_W:0]     trial;
    logic                   fits;

    assign trial = {p_q, dvd_q[DIVIDEND_W-1]};
    assign fits  = (trial >= {1'b0, dsr_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        p_d     = p_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    rem_d = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                quo_d = {quo_q[DIVIDEND_W-2:0], fits};
                // trial < 2*divisor, so the low bits of the difference are exact
                p_d   = fits ? (trial[DIVISOR_W-1:0] - dsr_q) : trial[DIVISOR_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    rem_d   = p_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            p_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            p_q     <= p_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
